// File: rtl/afe_cfg_pkg.sv
// Shared types and widths for the AFE config bus initiator.
package afe_cfg_pkg;

  localparam int CFG_ADDR_WIDTH = 11;
  localparam int CFG_DATA_WIDTH = 32;

  // One queued host command, exactly as it will be driven onto the bus.
  typedef struct packed {
    logic [CFG_ADDR_WIDTH-1:0] addr;
    logic [CFG_DATA_WIDTH-1:0] wdata;
    logic                      rwn;
  } cfg_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } cfg_init_state_e;

  // Writes always return zero data so a host never sees stale bus values.
  function automatic logic [CFG_DATA_WIDTH-1:0] rsp_data(
    input logic                      rwn,
    input logic [CFG_DATA_WIDTH-1:0] bus_data
  );
    return rwn ? bus_data : '0;
  endfunction

endpackage

// File: rtl/afe_cfg_cmd_fifo.sv
// Small synchronous command FIFO; the head is only visible one edge after
// it was written, so there is no fall-through path to the bus.
module afe_cfg_cmd_fifo
  import afe_cfg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  cfg_cmd_t                     push_cmd,
  input  logic                         pop,
  output cfg_cmd_t                     head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int LEVEL_WIDTH = $clog2(DEPTH+1);

  cfg_cmd_t             mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (level == LEVEL_WIDTH'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array, written only on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/afe_cfg_initiator.sv
// Config bus initiator: queues host commands and issues them one at a time,
// returning one in-order response (read data or timeout error) per command.
module afe_cfg_initiator
  import afe_cfg_pkg::*;
#(
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  cmd_valid_i,
  output logic                                  cmd_ready_o,
  input  logic [CFG_ADDR_WIDTH-1:0]             cmd_addr_i,
  input  logic [CFG_DATA_WIDTH-1:0]             cmd_wdata_i,
  input  logic                                  cmd_rwn_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [CFG_DATA_WIDTH-1:0]             rsp_rdata_o,
  output logic                                  rsp_rwn_o,
  output logic                                  rsp_err_o,
  output logic [CFG_ADDR_WIDTH-1:0]             cfg_addr_o,
  output logic [CFG_DATA_WIDTH-1:0]             cfg_wdata_o,
  output logic                                  cfg_valid_o,
  output logic                                  cfg_rwn_o,
  input  logic [CFG_DATA_WIDTH-1:0]             cfg_rdata_i,
  input  logic                                  cfg_ready_i,
  output logic                                  busy_o,
  output logic [$clog2(CMD_FIFO_DEPTH+1)-1:0]   fifo_level_o
);

  localparam bit TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);
  // Counter value seen at the last waiting edge before giving up.
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    TIMEOUT_ENABLED ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  cfg_init_state_e          state;
  cfg_cmd_t                 issue_cmd;
  cfg_cmd_t                 fifo_head;
  cfg_cmd_t                 new_cmd;
  logic [TIMEOUT_WIDTH-1:0] wait_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;

  assign new_cmd     = '{addr: cmd_addr_i, wdata: cmd_wdata_i, rwn: cmd_rwn_i};
  assign cmd_ready_o = !fifo_full;
  assign busy_o      = !fifo_empty || (state != IDLE);
  assign cfg_addr_o  = issue_cmd.addr;
  assign cfg_wdata_o = issue_cmd.wdata;
  assign cfg_rwn_o   = issue_cmd.rwn;

  // Take the next command whenever the bus side is free: from IDLE, or
  // straight out of RESP on the response handshake to avoid a bubble.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == RESP) && rsp_ready_i));

  afe_cfg_cmd_fifo #(
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (cmd_valid_i),
    .push_cmd (new_cmd),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level_o)
  );

  // Issue/response sequencer; every bus and response output is registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      issue_cmd   <= '0;
      wait_count  <= '0;
      cfg_valid_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_rwn_o   <= 1'b0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            issue_cmd   <= fifo_head;
            wait_count  <= '0;
            cfg_valid_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cfg_ready_i) begin
            cfg_valid_o <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rsp_data(issue_cmd.rwn, cfg_rdata_i);
            rsp_rwn_o   <= issue_cmd.rwn;
            rsp_err_o   <= 1'b0;
            state       <= RESP;
          end else if (TIMEOUT_ENABLED && (wait_count == TIMEOUT_LAST)) begin
            cfg_valid_o <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_rwn_o   <= issue_cmd.rwn;
            rsp_err_o   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            if (pop) begin
              issue_cmd   <= fifo_head;
              wait_count  <= '0;
              cfg_valid_o <= 1'b1;
              state       <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_afe_cfg_initiator.sv
// Self-checking bench for afe_cfg_initiator: directed scenarios plus a
// randomized run, all scored against a transaction-level model.
module tb_afe_cfg_initiator;
  import afe_cfg_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 8;
  localparam int LW    = $clog2(DEPTH+1);

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_rwn;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_rwn;
  logic        rsp_err;
  logic [10:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_valid;
  logic        cfg_rwn;
  logic [31:0] cfg_rdata;
  logic        cfg_ready;
  logic        busy;
  logic [LW-1:0] fifo_level;

  typedef struct packed {
    logic        rwn;
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  // Transaction-level model state
  cfg_cmd_t issue_q[$];
  exp_rsp_t rsp_q[$];
  cfg_cmd_t cur;
  logic     active = 1'b0;
  logic     expect_low = 1'b0;
  int       run_len = 0;
  int       pulse_count = 0;
  int       rsp_count = 0;
  int       last_run_len = 0;
  logic     last_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  afe_cfg_initiator #(
    .CMD_FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_WIDTH  (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_rwn_i    (cmd_rwn),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_rwn_o    (rsp_rwn),
    .rsp_err_o    (rsp_err),
    .cfg_addr_o   (cfg_addr),
    .cfg_wdata_o  (cfg_wdata),
    .cfg_valid_o  (cfg_valid),
    .cfg_rwn_o    (cfg_rwn),
    .cfg_rdata_i  (cfg_rdata),
    .cfg_ready_i  (cfg_ready),
    .busy_o       (busy),
    .fifo_level_o (fifo_level)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Responder returns a recognisable pattern derived from the address
  assign cfg_rdata = 32'hA5A5_0000 + {21'b0, cfg_addr};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic cv, input logic [10:0] a,
                               input logic [31:0] d, input logic rw,
                               input logic crdy, input logic rrdy);
    @(posedge clk);
    #1;
    rst       = r;
    cmd_valid = cv;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_rwn   = rw;
    cfg_ready = crdy;
    rsp_ready = rrdy;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input logic crdy, input logic rrdy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, crdy, rrdy);
    end
  endtask

  // Bus and response monitor: every accepted command must appear once on the
  // bus, in order, and produce exactly one matching response.
  initial begin
    cfg_cmd_t pushed;
    exp_rsp_t exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        issue_q.delete();
        rsp_q.delete();
        active     = 1'b0;
        expect_low = 1'b0;
        run_len    = 0;
      end else begin
        if (expect_low) begin
          checkOutput("cfg_valid_single_cycle", 32'(cfg_valid), 32'(0));
          expect_low = 1'b0;
        end else if (cfg_valid) begin
          if (!active) begin
            checkOutput("issue_has_cmd", 32'(issue_q.size() > 0), 32'(1));
            if (issue_q.size() > 0) begin
              cur = issue_q.pop_front();
              active = 1'b1;
              run_len = 0;
              pulse_count++;
            end
          end
          if (active) begin
            checkOutput("cfg_addr", 32'(cfg_addr), 32'(cur.addr));
            checkOutput("cfg_wdata", cfg_wdata, cur.wdata);
            checkOutput("cfg_rwn", 32'(cfg_rwn), 32'(cur.rwn));
            run_len++;
            if (cfg_ready || run_len == TO) begin
              exp.rwn   = cur.rwn;
              exp.err   = !cfg_ready;
              exp.rdata = (cfg_ready && cur.rwn) ? 32'hA5A5_0000 + 32'(cur.addr) : 32'h0;
              rsp_q.push_back(exp);
              last_run_len = run_len;
              last_err     = exp.err;
              active       = 1'b0;
              expect_low   = 1'b1;
            end
          end
        end else if (active) begin
          checkOutput("cfg_valid_held", 32'(cfg_valid), 32'(1));
          active = 1'b0;
        end
        if (rsp_valid) begin
          checkOutput("rsp_expected", 32'(rsp_q.size() > 0), 32'(1));
          if (rsp_q.size() > 0) begin
            checkOutput("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
            checkOutput("rsp_err", 32'(rsp_err), 32'(rsp_q[0].err));
            checkOutput("rsp_rwn", 32'(rsp_rwn), 32'(rsp_q[0].rwn));
            if (rsp_ready) begin
              void'(rsp_q.pop_front());
              rsp_count++;
            end
          end
        end
        if (cmd_valid && cmd_ready) begin
          pushed.addr  = cmd_addr;
          pushed.wdata = cmd_wdata;
          pushed.rwn   = cmd_rwn;
          issue_q.push_back(pushed);
        end
      end
    end
  end

  // Hard stop in case the design locks up
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized run
  initial begin
    int   p0;
    int   r0;
    int   guard;
    logic stuck;

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_rwn = 1'b0;
    cfg_ready = 1'b0; rsp_ready = 1'b0;

    // Reset values
    repeat (3) applyStimulus(1'b1, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'(1));
    checkOutput("reset_cfg_valid", 32'(cfg_valid), 32'(0));
    checkOutput("reset_cfg_addr", 32'(cfg_addr), 32'(0));
    checkOutput("reset_cfg_wdata", cfg_wdata, 32'h0);
    checkOutput("reset_cfg_rwn", 32'(cfg_rwn), 32'(0));
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'(0));
    checkOutput("reset_rsp_rwn", 32'(rsp_rwn), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_level", 32'(fifo_level), 32'(0));

    // Single write: latency and single-cycle valid
    applyStimulus(1'b0, 1'b1, 11'h7F8, 32'h0000_03FF, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("wr_no_fallthrough", 32'(cfg_valid), 32'(0));
    checkOutput("wr_level_queued", 32'(fifo_level), 32'(1));
    checkOutput("wr_busy_queued", 32'(busy), 32'(1));
    applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("wr_valid_e1", 32'(cfg_valid), 32'(1));
    checkOutput("wr_addr_e1", 32'(cfg_addr), 32'h7F8);
    checkOutput("wr_wdata_e1", cfg_wdata, 32'h0000_03FF);
    checkOutput("wr_level_popped", 32'(fifo_level), 32'(0));
    applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("wr_valid_e2", 32'(cfg_valid), 32'(0));
    checkOutput("wr_rsp_valid_e2", 32'(rsp_valid), 32'(1));
    checkOutput("wr_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("wr_rsp_err", 32'(rsp_err), 32'(0));
    applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("wr_rsp_done", 32'(rsp_valid), 32'(0));
    checkOutput("wr_idle_busy", 32'(busy), 32'(0));

    // Three back-to-back reads
    p0 = pulse_count; r0 = rsp_count;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 11'(16 + i), $urandom, 1'b1, 1'b1, 1'b1);
    end
    idleCycles(12, 1'b1, 1'b1);
    checkOutput("b2b_pulses", 32'(pulse_count - p0), 32'(3));
    checkOutput("b2b_responses", 32'(rsp_count - r0), 32'(3));

    // Wait states: ready asserted on the fourth valid cycle
    r0 = rsp_count;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'(i == 0), 11'h123, 32'hDEAD_BEEF, 1'b0, 1'(i == 5), 1'b1);
    end
    idleCycles(3, 1'b0, 1'b1);
    checkOutput("wait_valid_len", 32'(last_run_len), 32'(4));
    checkOutput("wait_err", 32'(last_err), 32'(0));
    checkOutput("wait_responses", 32'(rsp_count - r0), 32'(1));

    // Timeout, then a normal command
    r0 = rsp_count;
    applyStimulus(1'b0, 1'b1, 11'h055, 32'h0, 1'b1, 1'b0, 1'b1);
    idleCycles(14, 1'b0, 1'b1);
    checkOutput("timeout_valid_len", 32'(last_run_len), 32'(TO));
    checkOutput("timeout_err", 32'(last_err), 32'(1));
    checkOutput("timeout_responses", 32'(rsp_count - r0), 32'(1));
    applyStimulus(1'b0, 1'b1, 11'h056, 32'h0, 1'b1, 1'b1, 1'b1);
    idleCycles(5, 1'b1, 1'b1);
    checkOutput("after_timeout_err", 32'(last_err), 32'(0));
    checkOutput("after_timeout_len", 32'(last_run_len), 32'(1));
    checkOutput("after_timeout_responses", 32'(rsp_count - r0), 32'(2));

    // Backpressure until the FIFO is full
    r0 = rsp_count;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 11'(512 + i), $urandom, 1'(i % 2), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("full_cmd_ready", 32'(cmd_ready), 32'(0));
    checkOutput("full_level", 32'(fifo_level), 32'(DEPTH));
    checkOutput("full_busy", 32'(busy), 32'(1));
    checkOutput("full_rsp_stalled", 32'(rsp_valid), 32'(1));
    idleCycles(30, 1'b1, 1'b1);
    checkOutput("full_drain_responses", 32'(rsp_count - r0), 32'(5));
    checkOutput("full_drain_level", 32'(fifo_level), 32'(0));
    checkOutput("full_drain_busy", 32'(busy), 32'(0));

    // Reset while a command waits on the bus and another is queued
    applyStimulus(1'b0, 1'b1, 11'h301, 32'h1111_0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 11'h302, 32'h2222_0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("prerst_valid", 32'(cfg_valid), 32'(1));
    checkOutput("prerst_level", 32'(fifo_level), 32'(1));
    applyStimulus(1'b1, 1'b0, 11'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_mid_valid", 32'(cfg_valid), 32'(0));
    checkOutput("rst_mid_level", 32'(fifo_level), 32'(0));
    checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'(0));
    checkOutput("rst_mid_busy", 32'(busy), 32'(0));
    p0 = pulse_count;
    idleCycles(4, 1'b1, 1'b1);
    checkOutput("rst_no_retry", 32'(pulse_count - p0), 32'(0));

    // Randomized traffic with periodic stuck-ready windows to force timeouts
    for (int c = 0; c < 400; c++) begin
      stuck = ((c % 60) < 12);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 11'($urandom), $urandom,
                    1'($urandom_range(0, 1)),
                    stuck ? 1'b0 : 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) != 0));
    end
    guard = 0;
    while ((issue_q.size() != 0 || rsp_q.size() != 0 || active) && guard < 300) begin
      applyStimulus(1'b0, 1'b0, 11'h0, 32'h0, 1'b0, 1'b1, 1'b1);
      guard++;
    end
    checkOutput("random_drain_outstanding", 32'(issue_q.size() + rsp_q.size() + int'(active)), 32'(0));
    idleCycles(2, 1'b1, 1'b1);
    checkOutput("random_end_busy", 32'(busy), 32'(0));
    checkOutput("random_end_level", 32'(fifo_level), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/afe_cfg_initiator.md
Name: afe_cfg_initiator

Overview:
- Initiator (master) side of the AFE readout subsystem config bus (cfg_addr/cfg_wdata/cfg_valid/cfg_rwn/cfg_rdata/cfg_ready).
- Queues host register commands in a small FIFO and issues them one at a time on the config bus, waiting for ready.
- Returns one in-order response per command: read data or a timeout error.
- Used by on-chip sequencers or host bridges to program L2 channel, buffer and flag registers without tracking bus timing.

Parameters:
- CMD_FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
- TIMEOUT_CYCLES, 255, max cycles cfg_valid_o waits for cfg_ready_i; 0 disables timeout
- TIMEOUT_WIDTH, 8, counter width; must hold TIMEOUT_CYCLES

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command FIFO not full
- cmd_addr_i  in  11  register address
- cmd_wdata_i  in  32  write data
- cmd_rwn_i  in  1  1=read, 0=write
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  32  read data (0 for writes and errors)
- rsp_rwn_o  out  1  rwn of the completed command
- rsp_err_o  out  1  command timed out
- cfg_addr_o  out  11  config bus address
- cfg_wdata_o  out  32  config bus write data
- cfg_valid_o  out  1  config bus valid
- cfg_rwn_o  out  1  config bus read/not-write
- cfg_rdata_i  in  32  config bus read data (combinational from responder)
- cfg_ready_i  in  1  config bus ready
- busy_o  out  1  FIFO non-empty or FSM not IDLE
- fifo_level_o  out  $clog2(CMD_FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst_i sampled high at an edge): FIFO flushed, FSM to IDLE, timeout counter cleared, held response discarded.
- Reset values: cmd_ready_o=1, all cfg_* outputs 0, all rsp_* outputs 0, busy_o=0, fifo_level_o=0.
- Reset mid-ISSUE drops cfg_valid_o at that edge and does not retry the command.
- FIFO rules:
  - Push on cmd_valid_i & cmd_ready_o; cmd_ready_o = !full, with no bypass on same-cycle pop.
  - No fall-through: a command pushed at edge E0 can be popped at E1 at the earliest.
  - Level increments on push, decrements on pop, unchanged when both occur.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head into the issue register (addr/wdata/rwn), clear the timeout counter, go to ISSUE.
  - cfg_valid_o=0.
- ISSUE:
  - cfg_valid_o=1, with addr/wdata/rwn from the issue register, stable throughout.
  - cfg_ready_i=1 at an edge: capture cfg_rdata_i if rwn=1 (else 0), rsp_err=0, go to RESP. cfg_valid_o is 0 the next cycle.
  - cfg_ready_i=0: counter+1. If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 at that edge, complete with rsp_err=1, rdata=0, go to RESP.
  - Net effect: valid is high for exactly TIMEOUT_CYCLES cycles before a timeout.
- RESP:
  - rsp_valid_o=1; rsp_* outputs stable until rsp_ready_i.
  - On handshake: if the FIFO is non-empty, pop directly into ISSUE (no IDLE bubble), else go to IDLE.
- Single-cycle valid: with cfg_ready_i constant 1, each command produces exactly one cfg_valid_o cycle. This is mandatory because reads of the flag counter register clear it as a side effect.
- Latency, idle, ready=1:
  - cmd handshake at edge E0.
  - cfg_valid_o high from E1 to E2.
  - rsp_valid_o high from E2.
  - Next queued command valid one cycle after the rsp handshake.
- Ordering: responses are strictly in command order; writes also produce a response.
- Backpressure: rsp_ready_i=0 stalls in RESP; the FIFO keeps accepting until full.

Decomposition:
- Package afe_cfg_pkg:
  - CFG_ADDR_WIDTH=11, CFG_DATA_WIDTH=32.
  - cfg_cmd_t packed struct {addr, wdata, rwn}.
  - cfg_init_state_e enum {IDLE, ISSUE, RESP}.
- Sub-module afe_cfg_cmd_fifo: synchronous FIFO of cfg_cmd_t with push/pop/full/empty/level.

Test Plan:
- Write: cmd addr=0x7F8, wdata=0x3FF, rwn=0, ready=1 -> cfg_valid_o exactly 1 cycle with those values; rsp_valid_o one cycle later, rsp_rdata_o=0, rsp_err_o=0.
- Back-to-back reads: 3 reads queued, ready=1, rsp_ready_i=1, cfg_rdata_i=0xA5A50000+addr -> exactly 3 cfg_valid_o pulses, each 1 cycle wide; responses in order with matching data.
- Wait states: ready low 3 cycles then high -> cfg_valid_o high 4 cycles, addr/wdata stable throughout; one response, err=0.
- Timeout: TIMEOUT_CYCLES=8, ready stuck 0 -> valid high 8 cycles; rsp_err_o=1, rsp_rdata_o=0; next command then issues normally.
- Backpressure/full: rsp_ready_i=0, push 6 commands with DEPTH=4 -> 1 in ISSUE/RESP, 4 queued, cmd_ready_o=0, fifo_level_o=4; release rsp_ready_i -> all 5 complete in order.
- Reset mid-ISSUE: rst_i high 1 cycle while ready=0 -> next cycle cfg_valid_o=0, fifo_level_o=0, rsp_valid_o=0, busy_o=0.
